// File: rtl/dtr_pkg.sv
// dtr_pkg: shared FSM state type and elaboration-time timing helpers for the DTR scheduler
package dtr_pkg;
  typedef enum logic [1:0] {IDLE, START, CONVERT, CAPTURE} state_t;
  localparam int DTR_CONV_TIME_NS = 71000;
  // Round up so the conversion wait is never shorter than the primitive needs
  function automatic int conv_cycles(input longint ns, input longint hz);
    return int'((ns * hz + 999999999) / 1000000000);
  endfunction
  function automatic int period_cycles(input longint ms, input longint hz);
    return int'(ms * hz / 1000);
  endfunction
endpackage

// File: rtl/dtr_rr_arbiter.sv
// dtr_rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module dtr_rr_arbiter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         valid
);
  function automatic int wrap(input int a);
    return a >= N ? a - N : a;
  endfunction
  // Walk from farthest to nearest so the nearest pending index wins
  always_comb begin
    gnt = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (req[wrap(int'(ptr) + i)]) begin
        gnt = W'(wrap(int'(ptr) + i));
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/dtr_scheduler.sv
// dtr_scheduler: shares one DTR primitive among N_REQ requesters and a periodic source
module dtr_scheduler
  import dtr_pkg::*;
#(
  parameter int SYSTEM_FREQUENCY = 15000000,
  parameter int N_REQ            = 4,
  parameter int CONV_TIME_NS     = DTR_CONV_TIME_NS,
  parameter int PERIOD_MS        = 5000
) (
  input  logic                         i_Clk,
  input  logic                         i_Rstn,
  input  logic [N_REQ-1:0]             i_Req,
  output logic [N_REQ-1:0]             o_Ack,
  input  logic                         i_PeriodicEn,
  output logic                         o_Start,
  input  logic [7:0]                   i_DtrOut,
  output logic [7:0]                   o_Result,
  output logic                         o_ResultValid,
  output logic [$clog2(N_REQ+1)-1:0]   o_ResultSrc,
  output logic                         o_Busy
);
  localparam int SW = $clog2(N_REQ + 1);
  localparam int CONV_CYCLES = conv_cycles(longint'(CONV_TIME_NS), longint'(SYSTEM_FREQUENCY));
  localparam int PERIOD_CYCLES = period_cycles(longint'(PERIOD_MS), longint'(SYSTEM_FREQUENCY));
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(CONV_CYCLES - 1);
  localparam logic [PW-1:0] PMAX = PW'(PERIOD_CYCLES - 1);
  localparam logic [SW-1:0] PSRC = SW'(N_REQ);
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pcnt;
  logic pend, win_v;
  logic [SW-1:0] g, ptr, win;
  logic [N_REQ-1:0] blk;
  logic [N_REQ:0] cand;
  // blk hides the requester acked last cycle so its stale level cannot re-win
  assign cand = {pend, i_Req & ~blk};
  assign o_Busy = state != IDLE;
  dtr_rr_arbiter #(.N(N_REQ + 1), .W(SW)) u_arb (
    .req  (cand),
    .ptr  (ptr),
    .gnt  (win),
    .valid(win_v)
  );
  always_ff @(posedge i_Clk or negedge i_Rstn)
    if (!i_Rstn) begin
      pcnt <= '0;
      pend <= 1'b0;
    end else if (!i_PeriodicEn) begin
      pcnt <= '0;
      pend <= 1'b0;
    end else begin
      pcnt <= pcnt == PMAX ? '0 : pcnt + 1'b1;
      if (pcnt == PMAX) pend <= 1'b1;
      else if (state == CAPTURE && g == PSRC) pend <= 1'b0;
    end
  always_ff @(posedge i_Clk or negedge i_Rstn)
    if (!i_Rstn) begin
      state <= IDLE;
      o_Start <= 1'b0;
      o_Ack <= '0;
      o_ResultValid <= 1'b0;
      o_Result <= '0;
      o_ResultSrc <= '0;
      cnt <= '0;
      g <= '0;
      ptr <= '0;
      blk <= '0;
    end else begin
      o_Start <= 1'b0;
      o_Ack <= '0;
      o_ResultValid <= 1'b0;
      blk <= o_Ack;
      case (state)
        IDLE: if (win_v) begin
          g <= win;
          ptr <= win == PSRC ? '0 : win + 1'b1;
          o_Start <= 1'b1;
          state <= START;
        end
        START: begin
          cnt <= '0;
          state <= CONVERT;
        end
        // Outputs are registered, so the capture values load on entry to CAPTURE
        CONVERT: if (cnt == CMAX) begin
          o_Result <= i_DtrOut;
          o_ResultSrc <= g;
          o_ResultValid <= 1'b1;
          o_Ack <= g == PSRC ? '0 : N_REQ'(1) << g;
          state <= CAPTURE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dtr_scheduler.sv
// tb_dtr_scheduler: directed stimulus with scoreboard queues checked by an output monitor
module tb_dtr_scheduler;
  localparam int CONV = 71;
  logic i_Clk = 0, i_Rstn = 0, i_PeriodicEn = 0;
  logic [3:0] i_Req = 0;
  logic [7:0] i_DtrOut = 0;
  logic [3:0] o_Ack;
  logic o_Start, o_ResultValid, o_Busy;
  logic [7:0] o_Result;
  logic [2:0] o_ResultSrc;
  int cyc = 0, n_cmp = 0, n_bad = 0, d = 0;
  typedef struct {
    logic [3:0] ack;
    logic [2:0] src;
    logic [7:0] res;
    int at;
  } exp_t;
  exp_t exp_q[$];
  exp_t x;
  int st_q[$];

  dtr_scheduler #(.SYSTEM_FREQUENCY(1000000), .N_REQ(4), .CONV_TIME_NS(71000), .PERIOD_MS(1)) dut (
    .i_Clk        (i_Clk),
    .i_Rstn       (i_Rstn),
    .i_Req        (i_Req),
    .o_Ack        (o_Ack),
    .i_PeriodicEn (i_PeriodicEn),
    .o_Start      (o_Start),
    .i_DtrOut     (i_DtrOut),
    .o_Result     (o_Result),
    .o_ResultValid(o_ResultValid),
    .o_ResultSrc  (o_ResultSrc),
    .o_Busy       (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  // A conversion whose start is sampled at edge e shows o_Start after edge e and completes CONV+1 edges later
  task automatic expect_conv(input int e, input logic [3:0] ack, input logic [2:0] src, input logic [7:0] res);
    st_q.push_back(e);
    exp_q.push_back(exp_t'{ack, src, res, e + CONV + 1});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, o_Start, 0);
    chk({tag, "_ack"}, o_Ack, 0);
    chk({tag, "_valid"}, o_ResultValid, 0);
    chk({tag, "_busy"}, o_Busy, 0);
    chk({tag, "_result"}, o_Result, 0);
    chk({tag, "_src"}, o_ResultSrc, 0);
  endtask

  task automatic do_reset;
    i_Rstn = 0;
    i_Req = 0;
    i_PeriodicEn = 0;
    #1 chk_zero("rst");
    tick(3);
    i_Rstn = 1;
    tick(2);
  endtask

  always @(negedge i_Clk) if (i_Rstn) begin
    if (o_Start) begin
      if (st_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexp_start at cyc %0d", cyc);
      end else chk("start_cyc", cyc, st_q.pop_front());
    end
    if (o_ResultValid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexp_result: ack %b src %0d at cyc %0d", o_Ack, o_ResultSrc, cyc);
      end else begin
        x = exp_q.pop_front();
        chk("ack", o_Ack, x.ack);
        chk("src", o_ResultSrc, x.src);
        chk("result", o_Result, x.res);
        chk("result_cyc", cyc, x.at);
      end
    end else if (o_Ack != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_without_valid: ack %b at cyc %0d", o_Ack, cyc);
    end
  end

  initial begin
    do_reset();
    // single request latency and result hold
    i_DtrOut = 8'h5A;
    d = cyc;
    i_Req = 4'b0001;
    expect_conv(d + 1, 4'b0001, 3'd0, 8'h5A);
    tick(1);
    chk("busy_in_start", o_Busy, 1);
    tick(72);
    i_Req = 0;
    tick(8);
    chk("result_hold", o_Result, 8'h5A);
    // all requesters held: rotation 0,1,2,3,0 spaced 74
    do_reset();
    i_DtrOut = 8'hC3;
    d = cyc;
    i_Req = 4'hF;
    for (int i = 0; i < 5; i++) expect_conv(d + 1 + 74 * i, 4'(1 << (i % 4)), 3'(i % 4), 8'hC3);
    tick(73);
    tick(1);
    chk("idle_gap", o_Busy, 0);
    tick(74 * 4 - 1);
    i_Req = 0;
    tick(10);
    // withdrawn request gets nothing; request dropped after grant still acked
    do_reset();
    i_DtrOut = 8'h3C;
    d = cyc;
    i_Req = 4'b0001;
    expect_conv(d + 1, 4'b0001, 3'd0, 8'h3C);
    expect_conv(d + 75, 4'b0010, 3'd1, 8'h3C);
    tick(10);
    i_Req = 4'b0111;
    tick(1);
    i_Req = 4'b0011;
    tick(62);
    i_Req = 4'b0010;
    tick(2);
    i_Req = 0;
    tick(80);
    // periodic source, then disable clears the period counter
    do_reset();
    i_DtrOut = 8'hA5;
    d = cyc;
    i_PeriodicEn = 1;
    expect_conv(d + 1001, 4'b0000, 3'd4, 8'hA5);
    expect_conv(d + 2001, 4'b0000, 3'd4, 8'hA5);
    tick(2100);
    i_PeriodicEn = 0;
    tick(5);
    d = cyc;
    i_PeriodicEn = 1;
    expect_conv(d + 1001, 4'b0000, 3'd4, 8'hA5);
    tick(1080);
    i_PeriodicEn = 0;
    tick(5);
    // reset mid-conversion aborts with outputs cleared at once
    i_DtrOut = 8'h77;
    d = cyc;
    i_Req = 4'b0001;
    st_q.push_back(d + 1);
    tick(31);
    #2 i_Rstn = 0;
    #1 chk_zero("abort");
    i_Req = 0;
    tick(3);
    i_Rstn = 1;
    tick(20);
    d = cyc;
    i_Req = 4'b0100;
    expect_conv(d + 1, 4'b0100, 3'd2, 8'h77);
    tick(73);
    i_Req = 0;
    tick(5);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
